digit_feature_extract: RTL and testbench
========================================

// Module: digit_feature_extract
// PURPOSE
//  Streaming feature extractor for binarised digit frames. Counts black/white transitions along
//  N_ROWS horizontal probe rows and N_COLS vertical probe columns, and captures one feature
//  vector per frame behind a valid/ready handshake. Sits between the binarisation stage and
//  the digit classifier; probe count and position are parameters, not hard-wired.
// PARAMETERS
//  IMG_W    180          pixels per line (2..255)
//  IMG_H    240          lines per frame (2..255)
//  N_ROWS   2            horizontal probe rows
//  N_COLS   1            vertical probe columns
//  ROW_POS  {8'd160,8'd80}  packed row indices, entry r at [8r+:8]
//  COL_POS  {8'd90}      packed column indices, entry c at [8c+:8]
//  CNT_W    4            bits per transition counter (saturating)
// PORTS
//  video_clk   in   1               pixel clock
//  rst         in   1               synchronous reset, active-high
//  pix_valid   in   1               pixel strobe; pix/sof sampled only when high
//  pix         in   1               pixel, 0=black 1=white
//  sof         in   1               qualifies first pixel of a frame (x=0,y=0)
//  feat_row    out  N_ROWS*CNT_W    row transition counts, row r at [CNT_W*r+:CNT_W]
//  feat_col    out  N_COLS*CNT_W    column transition counts, same packing
//  quad        out  4               white-occupancy flags TL,TR,BL,BR = bit 0..3
//  feat_valid  out  1               feature vector valid
//  feat_ready  in   1               consumer accepts vector
//  frame_err   out  1               one-cycle pulse: frame aborted or dropped
// BEHAVIOUR
//  - States IDLE, SCAN, HOLD. Reset: state IDLE; all outputs, counters and x/y at 0.
//  - IDLE: pix_valid&&sof -> SCAN; this pixel is x=0,y=0. Pixels without sof are ignored.
//  - SCAN: each pix_valid advances x; at x=IMG_W-1, x wraps to 0 and y increments.
//  - Row r: when y==ROW_POS[r] and x>=1 and pix!=prev_pix (previous pixel of the same line),
//    increment cnt_row[r]. The first pixel of a line never counts.
//  - Col c: when x==COL_POS[c] and y>=1 and pix!=colprev[c] (pixel at column c on line y-1),
//    increment cnt_col[c]. colprev[c] updates whenever x==COL_POS[c].
//  - Counters saturate at 2^CNT_W-1 and never wrap.
//  - Last pixel (x=IMG_W-1,y=IMG_H-1) is included in the counts. Next cycle: feat_row,
//    feat_col and quad load and feat_valid=1; state -> HOLD. Latency is 1 cycle after last pixel.
//  - HOLD: outputs stable while feat_valid&&!feat_ready. On feat_valid&&feat_ready, feat_valid
//    drops next cycle and state -> IDLE. If pix_valid&&sof arrives in the same handshake cycle,
//    go straight to SCAN and count that pixel.
//  - sof in HOLD without ready: frame is dropped; frame_err pulses; state stays HOLD.
//  - sof in SCAN (mid-frame): abort. frame_err pulses; counters clear; new frame starts at
//    this pixel; outputs keep the previous vector.
//  - Working counters clear on entry to SCAN. Output registers change only on capture.
//  - rst at any point returns to IDLE within one cycle. No partial vector is ever presented.
// CONFIGURATION
//  DFE_QUAD_EN defined:
//   - Four sticky flags set by any white pixel in a quadrant (x<IMG_W/2, y<IMG_H/2 split,
//     integer division). Flags clear with the counters and are captured into quad.
//  DFE_QUAD_EN undefined:
//   - No quadrant logic is built and quad is tied to 4'b0000.
// TESTING (bench params IMG_W=8 IMG_H=6 N_ROWS=2 ROW_POS={8'd4,8'd2} N_COLS=1 COL_POS=8'd3)
//  - All-black frame -> feat_row=0, feat_col=0, quad=0, feat_valid 1 cycle after the 48th pixel.
//  - Row 2 = 0,1,0,1,0,0,0,0; column 3 alternates per line -> feat_row[3:0]=4,
//    feat_row[7:4]=0, feat_col=5.
//  - Row 4 alternating, CNT_W=2 -> feat_row[7:4] saturates at 3 and does not wrap.
//  - sof at pixel 20 of a frame -> frame_err pulse; next vector reflects only the new frame.
//  - Hold feat_ready=0, send a second frame -> frame_err at its sof; first vector unchanged.
//    Then ready=1 with sof in the same cycle -> third frame captured correctly.
//  - DFE_QUAD_EN defined, single white pixel at x=6,y=5 -> quad=4'b1000. Undefined -> quad=0.

Source files
------------

// File: rtl/digit_feature_extract.sv
// digit_feature_extract
// Streaming transition-count feature extractor for binarised digit frames.
// Counts black/white transitions along N_ROWS horizontal probe rows and
// N_COLS vertical probe columns, then presents one feature vector per frame
// behind a valid/ready handshake.
// Optional build macro: DFE_QUAD_EN adds four sticky white-occupancy flags
// (TL,TR,BL,BR); without it quad is tied low.
module digit_feature_extract #(
  parameter int                   IMG_W   = 180,
  parameter int                   IMG_H   = 240,
  parameter int                   N_ROWS  = 2,
  parameter int                   N_COLS  = 1,
  parameter logic [8*N_ROWS-1:0]  ROW_POS = {8'd160, 8'd80},
  parameter logic [8*N_COLS-1:0]  COL_POS = 8'd90,
  parameter int                   CNT_W   = 4
) (
  input  logic                      video_clk,
  input  logic                      rst,
  input  logic                      pix_valid,
  input  logic                      pix,
  input  logic                      sof,
  output logic [N_ROWS*CNT_W-1:0]   feat_row,
  output logic [N_COLS*CNT_W-1:0]   feat_col,
  output logic [3:0]                quad,
  output logic                      feat_valid,
  input  logic                      feat_ready,
  output logic                      frame_err
);

  localparam logic [7:0]       LAST_X  = 8'(IMG_W - 1);
  localparam logic [7:0]       LAST_Y  = 8'(IMG_H - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOLD} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_x, r_y;
  logic [7:0]        w_x, w_y;
  logic              r_prev_pix;
  logic [N_COLS-1:0] r_colprev;
  logic [CNT_W-1:0]  r_cnt_row [N_ROWS];
  logic [CNT_W-1:0]  r_cnt_col [N_COLS];
  logic [CNT_W-1:0]  w_row_nxt [N_ROWS];
  logic [CNT_W-1:0]  w_col_nxt [N_COLS];
  logic              w_start, w_abort, w_drop, w_pix_en, w_last;

  // Classify the incoming strobe: frame start, abort, drop, counted pixel.
  // A start restarts the coordinates at (0,0) for this very pixel.
  always_comb begin
    // NOTE: every combinational output gets a value before any branch, so no latch is inferred.
    w_start  = pix_valid && sof && ((r_state != S_HOLD) || feat_ready);
    w_abort  = pix_valid && sof && (r_state == S_SCAN);
    w_drop   = pix_valid && sof && (r_state == S_HOLD) && !feat_ready;
    w_pix_en = pix_valid && (w_start || (r_state == S_SCAN));
    w_x      = w_start ? 8'd0 : r_x;
    w_y      = w_start ? 8'd0 : r_y;
    w_last   = w_pix_en && (w_x == LAST_X) && (w_y == LAST_Y);
  end

  // Next-state decode; HOLD always has feat_valid high, so ready alone completes the handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_SCAN;
      S_SCAN:  if (w_last) w_state_nxt = S_HOLD;
      S_HOLD:  if (feat_ready) w_state_nxt = w_start ? S_SCAN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge video_clk) begin
    // NOTE: clocked state uses non-blocking assignment so all flops update from pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Saturating counter next values, including the current pixel, so capture sees the last pixel.
  always_comb begin
    for (int r = 0; r < N_ROWS; r++) begin
      w_row_nxt[r] = w_start ? '0 : r_cnt_row[r];
      if (w_pix_en && (w_x != 8'd0) && (w_y == ROW_POS[8*r +: 8]) &&
          (pix != r_prev_pix) && (r_cnt_row[r] != CNT_MAX))
        w_row_nxt[r] = r_cnt_row[r] + 1'b1;
    end
    for (int c = 0; c < N_COLS; c++) begin
      w_col_nxt[c] = w_start ? '0 : r_cnt_col[c];
      if (w_pix_en && (w_y != 8'd0) && (w_x == COL_POS[8*c +: 8]) &&
          (pix != r_colprev[c]) && (r_cnt_col[c] != CNT_MAX))
        w_col_nxt[c] = r_cnt_col[c] + 1'b1;
    end
  end

  // Coordinates, pixel history, working counters, output capture and handshake.
  always_ff @(posedge video_clk) begin
    if (rst) begin
      r_x        <= 8'd0;
      r_y        <= 8'd0;
      r_prev_pix <= 1'b0;
      r_colprev  <= '0;
      // NOTE: the counter arrays are a handful of flops, not a RAM, so they are reset like any register.
      for (int r = 0; r < N_ROWS; r++) r_cnt_row[r] <= '0;
      for (int c = 0; c < N_COLS; c++) r_cnt_col[c] <= '0;
      feat_row   <= '0;
      feat_col   <= '0;
      feat_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= w_drop || w_abort;
      for (int r = 0; r < N_ROWS; r++) r_cnt_row[r] <= w_row_nxt[r];
      for (int c = 0; c < N_COLS; c++) r_cnt_col[c] <= w_col_nxt[c];
      if (w_pix_en) begin
        r_prev_pix <= pix;
        if (w_x == LAST_X) begin
          r_x <= 8'd0;
          r_y <= w_y + 8'd1;
        end else begin
          r_x <= w_x + 8'd1;
          r_y <= w_y;
        end
        for (int c = 0; c < N_COLS; c++)
          if (w_x == COL_POS[8*c +: 8]) r_colprev[c] <= pix;
      end
      if (w_last) begin
        for (int r = 0; r < N_ROWS; r++) feat_row[CNT_W*r +: CNT_W] <= w_row_nxt[r];
        for (int c = 0; c < N_COLS; c++) feat_col[CNT_W*c +: CNT_W] <= w_col_nxt[c];
        feat_valid <= 1'b1;
      end else if ((r_state == S_HOLD) && feat_ready) begin
        feat_valid <= 1'b0;
      end
    end
  end

`ifdef DFE_QUAD_EN
  localparam logic [7:0] HALF_X = 8'(IMG_W / 2);
  localparam logic [7:0] HALF_Y = 8'(IMG_H / 2);

  logic [3:0] r_quad_acc;
  logic [3:0] w_quad_nxt;

  // Sticky quadrant flags; index = {bottom half, right half} gives TL,TR,BL,BR = 0..3.
  always_comb begin
    w_quad_nxt = w_start ? 4'b0000 : r_quad_acc;
    if (w_pix_en && pix) w_quad_nxt[{(w_y >= HALF_Y), (w_x >= HALF_X)}] = 1'b1;
  end

  // Quadrant accumulator and its captured copy.
  always_ff @(posedge video_clk) begin
    if (rst) begin
      r_quad_acc <= 4'b0000;
      quad       <= 4'b0000;
    end else begin
      r_quad_acc <= w_quad_nxt;
      if (w_last) quad <= w_quad_nxt;
    end
  end
`else
  assign quad = 4'b0000;
`endif

endmodule

// File: tb/tb_digit_feature_extract.sv
// tb_digit_feature_extract
// Drives two instances (4-bit and 2-bit counters) with the same pixel stream and
// compares their feature vectors against a frame-level reference model.
module tb_digit_feature_extract;

  localparam int W = 8;
  localparam int H = 6;
  localparam int ROW_Y [2] = '{2, 4};
  localparam int COL_X = 3;

  logic clk = 1'b0;
  logic rst, pix_valid, pix, sof, feat_ready;
  logic [7:0] row4; logic [3:0] col4; logic [3:0] quad4; logic fv4, err4;
  logic [3:0] row2; logic [1:0] col2; logic [3:0] quad2; logic fv2, err2;

  int checks = 0;
  int errors = 0;
  int err_seen4, err_seen2, early_valid;

  bit img [H][W];
  logic [7:0] exp_row4; logic [3:0] exp_col4;
  logic [3:0] exp_row2; logic [1:0] exp_col2;
  logic [3:0] exp_quad;

  always #5 clk = ~clk;

  digit_feature_extract #(
    .IMG_W(W), .IMG_H(H), .N_ROWS(2), .N_COLS(1),
    .ROW_POS({8'd4, 8'd2}), .COL_POS(8'd3), .CNT_W(4)
  ) dut4 (
    .video_clk(clk), .rst(rst), .pix_valid(pix_valid), .pix(pix), .sof(sof),
    .feat_row(row4), .feat_col(col4), .quad(quad4), .feat_valid(fv4),
    .feat_ready(feat_ready), .frame_err(err4)
  );

  digit_feature_extract #(
    .IMG_W(W), .IMG_H(H), .N_ROWS(2), .N_COLS(1),
    .ROW_POS({8'd4, 8'd2}), .COL_POS(8'd3), .CNT_W(2)
  ) dut2 (
    .video_clk(clk), .rst(rst), .pix_valid(pix_valid), .pix(pix), .sof(sof),
    .feat_row(row2), .feat_col(col2), .quad(quad2), .feat_valid(fv2),
    .feat_ready(feat_ready), .frame_err(err2)
  );

  // Reference model: transitions counted over the whole stored frame, then clipped.
  task automatic model_frame();
    int n;
    logic [3:0] q;
    for (int r = 0; r < 2; r++) begin
      n = 0;
      for (int x = 1; x < W; x++) if (img[ROW_Y[r]][x] != img[ROW_Y[r]][x-1]) n++;
      exp_row4[4*r +: 4] = 4'((n > 15) ? 15 : n);
      exp_row2[2*r +: 2] = 2'((n > 3) ? 3 : n);
    end
    n = 0;
    for (int y = 1; y < H; y++) if (img[y][COL_X] != img[y-1][COL_X]) n++;
    exp_col4 = 4'((n > 15) ? 15 : n);
    exp_col2 = 2'((n > 3) ? 3 : n);
    q = 4'b0000;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (img[y][x]) q[((y >= H/2) ? 2 : 0) + ((x >= W/2) ? 1 : 0)] = 1'b1;
`ifdef DFE_QUAD_EN
    exp_quad = q;
`else
    exp_quad = 4'b0000;
`endif
  endtask

  task automatic fill_random(input int density);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = ($urandom_range(0, 99) < density);
  endtask

  task automatic fill_const(input bit v);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = v;
  endtask

  // Sends raster pixels lo..hi-1 from img, sof on the first; optional idle gaps with garbage.
  task automatic send_pixels(input int lo, input int hi, input bit gaps, input bit valid_low);
    for (int i = lo; i < hi; i++) begin
      if (gaps && i != lo) begin
        int ng;
        ng = $urandom_range(0, 2);
        for (int g = 0; g < ng; g++) begin
          pix_valid = 1'b0; sof = 1'($urandom); pix = 1'($urandom);
          @(posedge clk); #1;
          if (err4) err_seen4++;
          if (err2) err_seen2++;
          if (valid_low && (fv4 || fv2)) early_valid++;
        end
      end
      pix_valid = 1'b1; sof = (i == lo); pix = img[i / W][i % W];
      @(posedge clk); #1;
      feat_ready = 1'b0;
      if (err4) err_seen4++;
      if (err2) err_seen2++;
      if (valid_low && (i != hi - 1) && (fv4 || fv2)) early_valid++;
    end
    pix_valid = 1'b0; sof = 1'b0; pix = 1'b0;
  endtask

  task automatic clear_obs();
    err_seen4 = 0; err_seen2 = 0; early_valid = 0;
  endtask

  task automatic consume();
    feat_ready = 1'b1;
    @(posedge clk); #1;
    feat_ready = 1'b0;
    checks++;
    if (fv4 !== 1'b0 || fv2 !== 1'b0) begin
      errors++; $display("FAIL handshake_drop feat_valid got %b/%b exp 0/0", fv4, fv2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_valid = 1'b0; pix = 1'b0; sof = 1'b0; feat_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({row4, col4, quad4, fv4, err4, row2, col2, quad2, fv2, err2} !== '0) begin
      errors++; $display("FAIL reset_state got %h_%h_%h_%b_%b / %h_%h_%h_%b_%b exp all zero",
                         row4, col4, quad4, fv4, err4, row2, col2, quad2, fv2, err2);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_all_black();
    // Pixels without sof while idle must be ignored.
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1'b1; sof = 1'b0; pix = 1'b1;
      @(posedge clk); #1;
    end
    fill_const(1'b0); model_frame(); clear_obs();
    send_pixels(0, W * H, 1'b0, 1'b1);
    checks++;
    if (early_valid != 0) begin
      errors++; $display("FAIL all_black_latency early valid cycles got %0d exp 0", early_valid);
    end
    checks++;
    if ({row4, col4, quad4, fv4} !== {exp_row4, exp_col4, exp_quad, 1'b1}) begin
      errors++; $display("FAIL all_black cnt4 got %h_%h_%h_%b exp %h_%h_%h_1", row4, col4, quad4, fv4, exp_row4, exp_col4, exp_quad);
    end
    checks++;
    if ({row2, col2, quad2, fv2} !== {exp_row2, exp_col2, exp_quad, 1'b1}) begin
      errors++; $display("FAIL all_black cnt2 got %h_%h_%h_%b exp %h_%h_%h_1", row2, col2, quad2, fv2, exp_row2, exp_col2, exp_quad);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({row4, col4, fv4} !== {exp_row4, exp_col4, 1'b1}) begin
      errors++; $display("FAIL all_black_hold got %h_%h_%b exp %h_%h_1", row4, col4, fv4, exp_row4, exp_col4);
    end
    consume();
  endtask

  task automatic test_pattern();
    fill_const(1'b0);
    for (int x = 0; x < W; x++) img[4][x] = 1'b1;
    img[2][1] = 1'b1; img[2][3] = 1'b1;
    for (int y = 0; y < H; y++) img[y][COL_X] = (y % 2 == 0);
    model_frame(); clear_obs();
    send_pixels(0, W * H, 1'b1, 1'b1);
    checks++;
    if ({row4, col4, fv4} !== {8'h04, 4'h5, 1'b1}) begin
      errors++; $display("FAIL pattern_const got row=%h col=%h v=%b exp row=04 col=5 v=1", row4, col4, fv4);
    end
    checks++;
    if ({row2, col2, quad2, fv2} !== {exp_row2, exp_col2, exp_quad, 1'b1}) begin
      errors++; $display("FAIL pattern cnt2 got %h_%h_%h_%b exp %h_%h_%h_1", row2, col2, quad2, fv2, exp_row2, exp_col2, exp_quad);
    end
    checks++;
    if (quad4 !== exp_quad) begin
      errors++; $display("FAIL pattern_quad got %b exp %b", quad4, exp_quad);
    end
    consume();
  endtask

  task automatic test_saturate();
    fill_random(50);
    for (int x = 0; x < W; x++) img[4][x] = x[0];
    model_frame(); clear_obs();
    send_pixels(0, W * H, 1'b1, 1'b1);
    checks++;
    if ({row4, col4, quad4, fv4} !== {exp_row4, exp_col4, exp_quad, 1'b1}) begin
      errors++; $display("FAIL saturate cnt4 got %h_%h_%h_%b exp %h_%h_%h_1", row4, col4, quad4, fv4, exp_row4, exp_col4, exp_quad);
    end
    checks++;
    if ({row2, col2, quad2, fv2} !== {exp_row2, exp_col2, exp_quad, 1'b1}) begin
      errors++; $display("FAIL saturate cnt2 got %h_%h_%h_%b exp %h_%h_%h_1", row2, col2, quad2, fv2, exp_row2, exp_col2, exp_quad);
    end
    consume();
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      fill_random($urandom_range(5, 95)); model_frame(); clear_obs();
      send_pixels(0, W * H, 1'b1, 1'b1);
      checks++;
      if (early_valid != 0 || err_seen4 != 0 || err_seen2 != 0) begin
        errors++; $display("FAIL random_ctrl frame %0d early=%0d err=%0d/%0d exp 0/0/0", f, early_valid, err_seen4, err_seen2);
      end
      checks++;
      if ({row4, col4, quad4, fv4} !== {exp_row4, exp_col4, exp_quad, 1'b1}) begin
        errors++; $display("FAIL random cnt4 frame %0d got %h_%h_%h_%b exp %h_%h_%h_1", f, row4, col4, quad4, fv4, exp_row4, exp_col4, exp_quad);
      end
      checks++;
      if ({row2, col2, quad2, fv2} !== {exp_row2, exp_col2, exp_quad, 1'b1}) begin
        errors++; $display("FAIL random cnt2 frame %0d got %h_%h_%h_%b exp %h_%h_%h_1", f, row2, col2, quad2, fv2, exp_row2, exp_col2, exp_quad);
      end
      consume();
    end
  endtask

  task automatic test_abort();
    // The outputs must still hold the previous (consumed) vector while a frame is aborted.
    fill_random(50); clear_obs();
    send_pixels(0, 20, 1'b1, 1'b1);
    checks++;
    if ({row4, col4, quad4, fv4} !== {exp_row4, exp_col4, exp_quad, 1'b0}) begin
      errors++; $display("FAIL abort_keep cnt4 got %h_%h_%h_%b exp %h_%h_%h_0", row4, col4, quad4, fv4, exp_row4, exp_col4, exp_quad);
    end
    fill_random(50); model_frame();
    send_pixels(0, W * H, 1'b1, 1'b1);
    checks++;
    if (err_seen4 != 1 || err_seen2 != 1 || early_valid != 0) begin
      errors++; $display("FAIL abort_err pulses got %0d/%0d early=%0d exp 1/1/0", err_seen4, err_seen2, early_valid);
    end
    checks++;
    if ({row4, col4, quad4, fv4} !== {exp_row4, exp_col4, exp_quad, 1'b1}) begin
      errors++; $display("FAIL abort_new cnt4 got %h_%h_%h_%b exp %h_%h_%h_1", row4, col4, quad4, fv4, exp_row4, exp_col4, exp_quad);
    end
    checks++;
    if ({row2, col2, quad2, fv2} !== {exp_row2, exp_col2, exp_quad, 1'b1}) begin
      errors++; $display("FAIL abort_new cnt2 got %h_%h_%h_%b exp %h_%h_%h_1", row2, col2, quad2, fv2, exp_row2, exp_col2, exp_quad);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    fill_random(40); model_frame(); clear_obs();
    send_pixels(0, W * H, 1'b1, 1'b1);
    // Second frame arrives while the first vector is unconsumed: dropped.
    fill_random(60); clear_obs();
    send_pixels(0, W * H, 1'b1, 1'b0);
    checks++;
    if (err_seen4 != 1 || err_seen2 != 1) begin
      errors++; $display("FAIL drop_err pulses got %0d/%0d exp 1/1", err_seen4, err_seen2);
    end
    checks++;
    if ({row4, col4, quad4, fv4} !== {exp_row4, exp_col4, exp_quad, 1'b1}) begin
      errors++; $display("FAIL drop_hold cnt4 got %h_%h_%h_%b exp %h_%h_%h_1", row4, col4, quad4, fv4, exp_row4, exp_col4, exp_quad);
    end
    checks++;
    if ({row2, col2, quad2, fv2} !== {exp_row2, exp_col2, exp_quad, 1'b1}) begin
      errors++; $display("FAIL drop_hold cnt2 got %h_%h_%h_%b exp %h_%h_%h_1", row2, col2, quad2, fv2, exp_row2, exp_col2, exp_quad);
    end
    // Third frame: sof coincides with the accepting handshake.
    fill_random(50); model_frame(); clear_obs();
    feat_ready = 1'b1;
    send_pixels(0, W * H, 1'b1, 1'b1);
    checks++;
    if (err_seen4 != 0 || err_seen2 != 0 || early_valid != 0) begin
      errors++; $display("FAIL b2b_ctrl err=%0d/%0d early=%0d exp 0/0/0", err_seen4, err_seen2, early_valid);
    end
    checks++;
    if ({row4, col4, quad4, fv4} !== {exp_row4, exp_col4, exp_quad, 1'b1}) begin
      errors++; $display("FAIL b2b cnt4 got %h_%h_%h_%b exp %h_%h_%h_1", row4, col4, quad4, fv4, exp_row4, exp_col4, exp_quad);
    end
    checks++;
    if ({row2, col2, quad2, fv2} !== {exp_row2, exp_col2, exp_quad, 1'b1}) begin
      errors++; $display("FAIL b2b cnt2 got %h_%h_%h_%b exp %h_%h_%h_1", row2, col2, quad2, fv2, exp_row2, exp_col2, exp_quad);
    end
    consume();
  endtask

  task automatic test_quad();
    fill_const(1'b0); img[5][6] = 1'b1; model_frame(); clear_obs();
    send_pixels(0, W * H, 1'b1, 1'b1);
    checks++;
`ifdef DFE_QUAD_EN
    if (quad4 !== 4'b1000 || quad2 !== 4'b1000) begin
      errors++; $display("FAIL quad_single got %b/%b exp 1000", quad4, quad2);
    end
`else
    if (quad4 !== 4'b0000 || quad2 !== 4'b0000) begin
      errors++; $display("FAIL quad_single got %b/%b exp 0000", quad4, quad2);
    end
`endif
    checks++;
    if ({row4, col4, quad4, fv4} !== {exp_row4, exp_col4, exp_quad, 1'b1}) begin
      errors++; $display("FAIL quad cnt4 got %h_%h_%h_%b exp %h_%h_%h_1", row4, col4, quad4, fv4, exp_row4, exp_col4, exp_quad);
    end
    consume();
  endtask

  task automatic test_reset_midframe();
    fill_random(50);
    send_pixels(0, 10, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({row4, col4, quad4, fv4, row2, col2, quad2, fv2} !== '0) begin
      errors++; $display("FAIL reset_mid got %h_%h_%h_%b / %h_%h_%h_%b exp all zero", row4, col4, quad4, fv4, row2, col2, quad2, fv2);
    end
    rst = 1'b0;
    fill_random(50); model_frame(); clear_obs();
    send_pixels(0, W * H, 1'b1, 1'b1);
    checks++;
    if ({row4, col4, quad4, fv4} !== {exp_row4, exp_col4, exp_quad, 1'b1}) begin
      errors++; $display("FAIL reset_mid_next cnt4 got %h_%h_%h_%b exp %h_%h_%h_1", row4, col4, quad4, fv4, exp_row4, exp_col4, exp_quad);
    end
    checks++;
    if ({row2, col2, quad2, fv2} !== {exp_row2, exp_col2, exp_quad, 1'b1}) begin
      errors++; $display("FAIL reset_mid_next cnt2 got %h_%h_%h_%b exp %h_%h_%h_1", row2, col2, quad2, fv2, exp_row2, exp_col2, exp_quad);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_all_black();
    test_pattern();
    test_saturate();
    test_random();
    test_abort();
    test_back_to_back();
    test_quad();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
